// File: rtl/keypad_encoder_4x4.sv
// keypad_encoder_4x4: scans a 4x4 active-low keypad, debounces, priority-encodes the key and hands it off via valid/ack.
module keypad_encoder_4x4 #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       valid,
  input  logic       ack,
  output logic       multi
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {SCAN, DEB, REPORT, RELEASE} state_t;
  state_t state, state_d;
  logic [3:0] c1, c2, samp, acc_idx, f_idx, cand, cand_d, code, code_d;
  logic [DW-1:0] dcnt;
  logic [1:0] r, row_col;
  logic [CW-1:0] cnt, cnt_d;
  logic acc_hit, acc_mult, last, fend, row_hit, row_mult, f_hit, f_mult, mult_d, valid_d;
  assign row_n = ~(4'b0001 << r);
  assign {D, C, B, A} = code;
  assign last = dcnt == DW'(SCAN_DIV - 1);
  assign fend = last && r == 2'd3;
  assign samp = ~c2;
  assign row_hit = |samp;
  assign row_col = samp[0] ? 2'd0 : samp[1] ? 2'd1 : samp[2] ? 2'd2 : 2'd3;
  assign row_mult = (samp & (samp - 4'd1)) != 4'd0;
  // Rows are scanned in ascending order, so the first hit in a frame is the lowest index.
  assign f_hit = acc_hit | row_hit;
  assign f_idx = acc_hit ? acc_idx : {r, row_col};
  assign f_mult = acc_mult | row_mult | (acc_hit & row_hit);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1 <= 4'hf;
      c2 <= 4'hf;
      dcnt <= '0;
      r <= 2'd0;
      acc_hit <= 1'b0;
      acc_mult <= 1'b0;
      acc_idx <= 4'd0;
    end else begin
      c1 <= col_n;
      c2 <= c1;
      dcnt <= last ? '0 : dcnt + DW'(1);
      if (last) begin
        r <= r + 2'd1;
        acc_hit <= f_hit & ~fend;
        acc_mult <= f_mult & ~fend;
        acc_idx <= fend ? 4'd0 : f_idx;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SCAN;
      cand <= 4'd0;
      cnt <= '0;
      code <= 4'd0;
      multi <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      cand <= cand_d;
      cnt <= cnt_d;
      code <= code_d;
      multi <= mult_d;
      valid <= valid_d;
    end
  end
  always_comb begin
    state_d = state;
    cand_d = cand;
    cnt_d = cnt;
    code_d = code;
    mult_d = multi;
    case (state)
      SCAN: if (fend && f_hit) begin
        cand_d = f_idx;
        cnt_d = CW'(1);
        state_d = DEBOUNCE == 1 ? REPORT : DEB;
      end
      DEB: if (fend) begin
        if (f_hit && f_idx == cand) begin
          cnt_d = cnt + CW'(1);
          if (cnt_d == CW'(DEBOUNCE)) state_d = REPORT;
        end else begin
          cnt_d = '0;
          state_d = SCAN;
        end
      end
      REPORT: if (ack) begin
        cnt_d = '0;
        state_d = RELEASE;
      end
      RELEASE: if (fend) begin
        cnt_d = f_hit ? '0 : cnt + CW'(1);
        if (cnt_d == CW'(DEBOUNCE)) begin
          cnt_d = '0;
          state_d = SCAN;
        end
      end
    endcase
    if (state != REPORT && state_d == REPORT) begin
      code_d = cand_d;
      mult_d = f_mult;
    end
    valid_d = state_d == REPORT;
  end
endmodule

// File: tb/tb_keypad_encoder_4x4.sv
// tb_keypad_encoder_4x4: directed tests of scanning, debounce, handshake, multi-key and async reset.
module tb_keypad_encoder_4x4;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ack = 1'b0;
  logic [3:0] col_n, row_n;
  logic A, B, C, D, valid, multi;
  logic [15:0] keys = 16'd0;
  int total = 0;
  int bad = 0;
  keypad_encoder_4x4 #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .reset_n(reset_n), .col_n(col_n), .row_n(row_n),
    .A(A), .B(B), .C(C), .D(D), .valid(valid), .ack(ack), .multi(multi)
  );
  always #5 clk = ~clk;
  // Passive keypad: a pressed key shorts its row line to its column line.
  always_comb begin
    col_n = 4'hf;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!row_n[i] && keys[i*4+j]) col_n[j] = 1'b0;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset;
    ack = 1'b0;
    keys = 16'd0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_reset;
    logic [3:0] er;
    ack = 1'b0;
    keys = 16'd0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL reset_row: got %b want 1110", row_n); end
    total++; if ({D, C, B, A} !== 4'b0000) begin bad++; $display("FAIL reset_code: got %b want 0000", {D, C, B, A}); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL reset_multi: got %b want 0", multi); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      er = ~(4'b0001 << ((k / 4) % 4));
      total++; if (row_n !== er) begin bad++; $display("FAIL scan_row k=%0d: got %b want %b", k, row_n, er); end
      total++; if (valid !== 1'b0 || {D, C, B, A} !== 4'b0000) begin bad++; $display("FAIL idle_out k=%0d: got valid=%b code=%b want 0/0000", k, valid, {D, C, B, A}); end
    end
  endtask
  task automatic test_report;
    do_reset;
    keys[9] = 1'b1;
    tick(31);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", valid); end
    tick(1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL report_valid: got %b want 1", valid); end
    total++; if ({D, C, B, A} !== 4'b1001) begin bad++; $display("FAIL report_code: got %b want 1001", {D, C, B, A}); end
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL report_multi: got %b want 0", multi); end
    for (int k = 0; k < 10; k++) begin
      tick(1);
      total++; if (valid !== 1'b1 || {D, C, B, A} !== 4'b1001) begin bad++; $display("FAIL hold k=%0d: got valid=%b code=%b want 1/1001", k, valid, {D, C, B, A}); end
    end
  endtask
  task automatic test_ack_release;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ack_drop: got %b want 0", valid); end
    total++; if ({D, C, B, A} !== 4'b1001) begin bad++; $display("FAIL ack_code: got %b want 1001", {D, C, B, A}); end
    for (int k = 0; k < 48; k++) begin
      tick(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL held_rereport k=%0d: got %b want 0", k, valid); end
    end
    keys = 16'd0;
    for (int k = 0; k < 37; k++) begin
      tick(1);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL release_valid k=%0d: got %b want 0", k, valid); end
    end
    keys[9] = 1'b1;
    tick(31);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL repress_early: got %b want 0", valid); end
    tick(1);
    total++; if (valid !== 1'b1 || {D, C, B, A} !== 4'b1001) begin bad++; $display("FAIL repress: got valid=%b code=%b want 1/1001", valid, {D, C, B, A}); end
  endtask
  task automatic test_bounce;
    do_reset;
    ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      keys[3] = 1'b1;
      for (int k = 0; k < 16; k++) begin
        tick(1);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bounce_press n=%0d k=%0d: got %b want 0", n, k, valid); end
      end
      keys = 16'd0;
      for (int k = 0; k < 16; k++) begin
        tick(1);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL bounce_rel n=%0d k=%0d: got %b want 0", n, k, valid); end
      end
    end
    tick(32);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bounce_tail: got %b want 0", valid); end
    ack = 1'b0;
  endtask
  task automatic test_ack_held;
    do_reset;
    ack = 1'b1;
    keys[9] = 1'b1;
    tick(32);
    total++; if (valid !== 1'b1 || {D, C, B, A} !== 4'b1001) begin bad++; $display("FAIL ackheld_entry: got valid=%b code=%b want 1/1001", valid, {D, C, B, A}); end
    tick(1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ackheld_pulse: got %b want 0", valid); end
    tick(20);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ackheld_after: got %b want 0", valid); end
    ack = 1'b0;
  endtask
  task automatic test_multi_and_async_reset;
    do_reset;
    keys = (16'd1 << 5) | (16'd1 << 14);
    tick(32);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL multi_valid: got %b want 1", valid); end
    total++; if ({D, C, B, A} !== 4'b0101) begin bad++; $display("FAIL multi_code: got %b want 0101", {D, C, B, A}); end
    total++; if (multi !== 1'b1) begin bad++; $display("FAIL multi_flag: got %b want 1", multi); end
    keys = 16'd1;
    for (int k = 0; k < 48; k++) begin
      tick(1);
      total++; if (valid !== 1'b1 || {D, C, B, A} !== 4'b0101) begin bad++; $display("FAIL change_in_report k=%0d: got valid=%b code=%b want 1/0101", k, valid, {D, C, B, A}); end
    end
    tick(5);
    total++; if (row_n !== 4'b1101) begin bad++; $display("FAIL pre_reset_row: got %b want 1101", row_n); end
    #3;
    reset_n = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", valid); end
    total++; if ({D, C, B, A} !== 4'b0000) begin bad++; $display("FAIL async_code: got %b want 0000", {D, C, B, A}); end
    total++; if (multi !== 1'b0) begin bad++; $display("FAIL async_multi: got %b want 0", multi); end
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL async_row: got %b want 1110", row_n); end
    @(negedge clk);
    reset_n = 1'b1;
    keys = 16'd0;
  endtask
  initial begin
    test_reset;
    test_report;
    test_ack_release;
    test_bounce;
    test_ack_held;
    test_multi_and_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
